sram_read_arbiter: RTL and testbench

SRAM_READ_ARBITER -- requirements
Module: sram_read_arbiter

---
 rtl/sram_read_arbiter.sv | 127 ++++++++++++
 tb/tb_sram_read_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_read_arbiter.sv
// Two-requester round-robin burst read arbiter for a single-port SRAM.
// Grants one burst at a time and returns data tagged with the owning requester.
module sram_read_arbiter #(
    parameter int SRAM_DEPTH  = 262144,
    parameter int SRAM_ADDR_W = 18,
    parameter int LEN_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [SRAM_ADDR_W-1:0] req0_addr,
    input  logic [LEN_W-1:0]       req0_len,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [SRAM_ADDR_W-1:0] req1_addr,
    input  logic [LEN_W-1:0]       req1_len,
    output logic                   sram_en,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [63:0]            sram_data,
    output logic [63:0]            rd_data,
    output logic                   rd_valid,
    output logic                   rd_id,
    output logic                   rd_last
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [SRAM_ADDR_W-1:0] ADDR_LAST = SRAM_ADDR_W'(SRAM_DEPTH - 1);
    localparam logic [LEN_W-1:0]       LEN_ONE   = LEN_W'(1);

    state_t                 state, state_nxt;
    logic [LEN_W-1:0]       count, count_nxt;
    logic                   owner, owner_nxt;
    logic                   last_grant, last_grant_nxt;
    logic                   en_nxt;
    logic [SRAM_ADDR_W-1:0] addr_nxt;

    logic                   any_valid;
    logic                   gnt;
    logic                   accept;
    logic [SRAM_ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]       sel_len;

    // Read data is passed straight through; the SRAM already registers it.
    assign rd_data = sram_data;

    // Round-robin grant and ready: ready only in IDLE and never during reset.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        gnt       = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt = ~last_grant;
        end else begin
            gnt = req1_valid;
        end
        req0_ready = reset_n && (state == IDLE) && any_valid && !gnt;
        req1_ready = reset_n && (state == IDLE) && any_valid && gnt;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        sel_addr   = gnt ? req1_addr : req0_addr;
        sel_len    = gnt ? req1_len : req0_len;
    end

    // Next-state and next-datapath values for the burst FSM.
    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        en_nxt         = sram_en;
        addr_nxt       = sram_addr;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    last_grant_nxt = gnt;
                    if (sel_len != '0) begin
                        owner_nxt = gnt;
                        count_nxt = sel_len;
                        addr_nxt  = sel_addr;
                        en_nxt    = 1'b1;
                        state_nxt = BURST;
                    end
                end
            end
            BURST: begin
                if (count > LEN_ONE) begin
                    addr_nxt  = (sram_addr == ADDR_LAST) ? '0 : sram_addr + 1'b1;
                    count_nxt = count - 1'b1;
                end else begin
                    count_nxt = '0;
                    en_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, SRAM command and return-path registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            sram_en    <= 1'b0;
            sram_addr  <= '0;
            count      <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rd_valid   <= 1'b0;
            rd_id      <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sram_en    <= en_nxt;
            sram_addr  <= addr_nxt;
            count      <= count_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            rd_valid   <= sram_en;
            rd_id      <= owner;
            rd_last    <= sram_en && (count == LEN_ONE);
        end
    end

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter: a cycle table plus sequences
// for fairness and reset in the middle of a burst.
module tb_sram_read_arbiter;

    localparam int AW = 18;
    localparam int LW = 16;
    localparam logic [63:0] MAGIC = 64'hC0DE_0000_0000_0000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [LW-1:0] req0_len, req1_len;
    logic          sram_en;
    logic [AW-1:0] sram_addr;
    logic [63:0]   sram_data = '0;
    logic [63:0]   rd_data;
    logic          rd_valid, rd_id, rd_last;

    int n_cmp = 0;
    int n_bad = 0;

    sram_read_arbiter #(
        .SRAM_DEPTH (262144),
        .SRAM_ADDR_W(AW),
        .LEN_W      (LW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_addr (req0_addr),
        .req0_len  (req0_len),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_addr (req1_addr),
        .req1_len  (req1_len),
        .sram_en   (sram_en),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_id     (rd_id),
        .rd_last   (rd_last)
    );

    always #5 clk = ~clk;

    // SRAM model: data returned one cycle after the enable, tagged by address.
    always @(posedge clk) begin
        if (sram_en) sram_data <= MAGIC | 64'(sram_addr);
    end

    typedef struct {
        logic          rst;
        logic          v0;
        logic [AW-1:0] a0;
        logic [LW-1:0] l0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [LW-1:0] l1;
        logic          r0;
        logic          r1;
        logic          en;
        logic [AW-1:0] addr;
        logic          rv;
        logic          id;
        logic          last;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl[NV];

    function automatic vec_t mk(
        input logic rst, input logic v0, input int a0, input int l0,
        input logic v1, input int a1, input int l1,
        input logic r0, input logic r1, input logic en, input int addr,
        input logic rv, input logic id, input logic last);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.a0 = AW'(a0); v.l0 = LW'(l0);
        v.v1 = v1; v.a1 = AW'(a1); v.l1 = LW'(l1);
        v.r0 = r0; v.r1 = r1; v.en = en; v.addr = AW'(addr);
        v.rv = rv; v.id = id; v.last = last;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v0, input int a0,
                         input int l0, input logic v1, input int a1,
                         input int l1);
        reset_n    = rst;
        req0_valid = v0;
        req0_addr  = AW'(a0);
        req0_len   = LW'(l0);
        req1_valid = v1;
        req1_addr  = AW'(a1);
        req1_len   = LW'(l1);
    endtask

    initial begin
        // rst v0 a0 l0 v1 a1 l1 | r0 r1 | en addr rv id last (after edge)
        tbl[0]  = mk(0, 1, 'h100, 4, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 'h100, 4, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 'h100, 4, 0, 0, 0,  1, 0,  1, 'h100, 0, 0, 0);
        tbl[3]  = mk(1, 1, 'h555, 9, 0, 0, 0,  0, 0,  1, 'h101, 1, 0, 0);
        tbl[4]  = mk(1, 1, 'h555, 9, 0, 0, 0,  0, 0,  1, 'h102, 1, 0, 0);
        tbl[5]  = mk(1, 1, 'h555, 9, 0, 0, 0,  0, 0,  1, 'h103, 1, 0, 0);
        tbl[6]  = mk(1, 1, 'h555, 9, 0, 0, 0,  0, 0,  0, 'h103, 1, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0,      0, 0,  0, 'h103, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, 'h20, 2, 1, 'h40, 2, 1, 0, 1, 'h20, 0, 0, 0);
        tbl[10] = mk(1, 0, 0, 0, 1, 'h40, 2,   0, 0,  1, 'h21, 1, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 1, 'h40, 2,   0, 0,  0, 'h21, 1, 0, 1);
        tbl[12] = mk(1, 0, 0, 0, 1, 'h40, 2,   0, 1,  1, 'h40, 0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0,      0, 0,  1, 'h41, 1, 1, 0);
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 0,      0, 0,  0, 'h41, 1, 1, 1);
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0,      0, 0,  0, 'h41, 0, 1, 0);
        tbl[16] = mk(1, 1, 'h77, 0, 0, 0, 0,   1, 0,  0, 'h41, 0, 1, 0);
        tbl[17] = mk(1, 1, 'h77, 0, 1, 'h88, 1, 0, 1, 1, 'h88, 0, 1, 0);
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 0,      0, 0,  0, 'h88, 1, 1, 1);
        tbl[19] = mk(1, 0, 0, 0, 0, 0, 0,      0, 0,  0, 'h88, 0, 1, 0);
        tbl[20] = mk(1, 0, 0, 0, 1, 'h3FFFE, 4, 0, 1, 1, 'h3FFFE, 0, 1, 0);
        tbl[21] = mk(1, 0, 0, 0, 0, 0, 0,      0, 0,  1, 'h3FFFF, 1, 1, 0);
        tbl[22] = mk(1, 0, 0, 0, 0, 0, 0,      0, 0,  1, 'h0, 1, 1, 0);
        tbl[23] = mk(1, 0, 0, 0, 0, 0, 0,      0, 0,  1, 'h1, 1, 1, 0);
        tbl[24] = mk(1, 0, 0, 0, 0, 0, 0,      0, 0,  0, 'h1, 1, 1, 1);
        tbl[25] = mk(1, 0, 0, 0, 0, 0, 0,      0, 0,  0, 'h1, 0, 1, 0);

        drive(0, 0, 0, 0, 0, 0, 0);

        // Table: inputs at negedge, ready just after, registers after posedge.
        begin
            logic [AW-1:0] prev_addr;
            prev_addr = '0;
            for (int i = 0; i < NV; i++) begin
                @(negedge clk);
                drive(tbl[i].rst, tbl[i].v0, int'(tbl[i].a0), int'(tbl[i].l0),
                      tbl[i].v1, int'(tbl[i].a1), int'(tbl[i].l1));
                #1;
                chk($sformatf("v%0d req0_ready", i), 64'(req0_ready), 64'(tbl[i].r0));
                chk($sformatf("v%0d req1_ready", i), 64'(req1_ready), 64'(tbl[i].r1));
                @(posedge clk);
                #1;
                chk($sformatf("v%0d sram_en", i), 64'(sram_en), 64'(tbl[i].en));
                chk($sformatf("v%0d sram_addr", i), 64'(sram_addr), 64'(tbl[i].addr));
                chk($sformatf("v%0d rd_valid", i), 64'(rd_valid), 64'(tbl[i].rv));
                chk($sformatf("v%0d rd_id", i), 64'(rd_id), 64'(tbl[i].id));
                chk($sformatf("v%0d rd_last", i), 64'(rd_last), 64'(tbl[i].last));
                if (tbl[i].rv)
                    chk($sformatf("v%0d rd_data", i), rd_data, MAGIC | 64'(prev_addr));
                prev_addr = tbl[i].addr;
            end
        end

        // Fairness: both held valid, grants must alternate starting with 0.
        begin
            int grants[4];
            int ng;
            ng = 0;
            for (int c = 0; c < 60 && ng < 4; c++) begin
                @(negedge clk);
                drive(1, 1, 'h400, 3, 1, 'h500, 3);
                #1;
                if (sram_en) begin
                    chk("fair ready0 in burst", 64'(req0_ready), 64'd0);
                    chk("fair ready1 in burst", 64'(req1_ready), 64'd0);
                end
                if (req0_ready) grants[ng++] = 0;
                else if (req1_ready) grants[ng++] = 1;
                @(posedge clk);
            end
            chk("fair grant count", 64'(ng), 64'd4);
            for (int g = 0; g < ng; g++)
                chk($sformatf("fair grant %0d", g), 64'(grants[g]), 64'(g % 2));
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 6; c++) @(negedge clk);
        end

        // Reset in the 3rd burst cycle aborts the burst and its in-flight beat.
        begin
            int en_cnt, rv_cnt, lasts;
            drive(1, 1, 'h200, 8, 0, 0, 0);
            @(posedge clk); #1;
            chk("rst accept en", 64'(sram_en), 64'd1);
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
            @(negedge clk);
            @(posedge clk); #1;
            chk("rst burst addr", 64'(sram_addr), 64'h202);
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
            chk("rst sram_en", 64'(sram_en), 64'd0);
            chk("rst rd_valid", 64'(rd_valid), 64'd0);
            chk("rst sram_addr", 64'(sram_addr), 64'd0);
            @(negedge clk);
            drive(1, 0, 0, 0, 1, 'h300, 3);
            #1;
            chk("post-rst ready1", 64'(req1_ready), 64'd1);
            @(posedge clk); #1;
            chk("post-rst rd_valid", 64'(rd_valid), 64'd0);
            chk("post-rst first addr", 64'(sram_addr), 64'h300);
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 0, 0);
            en_cnt = 1;
            rv_cnt = 0;
            lasts  = 0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (sram_en) begin
                    chk("post-rst addr", 64'(sram_addr), 64'h300 + 64'(en_cnt));
                    en_cnt++;
                end
                if (rd_valid) begin
                    chk("post-rst rd_id", 64'(rd_id), 64'd1);
                    rv_cnt++;
                end
                if (rd_last) lasts++;
            end
            chk("post-rst beats en", 64'(en_cnt), 64'd3);
            chk("post-rst beats rv", 64'(rv_cnt), 64'd3);
            chk("post-rst last", 64'(lasts), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
